// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg
// Shared types and helpers for the multi-channel edge detector
// (edge_detect_multi / edge_detect_chan).
//   edge_mode_e  : 2-bit per-channel edge select (none / rise / fall / both)
//   chan_mode()  : pulls channel idx's 2-bit field out of a packed mode bus
// Optional feature macro used by the RTL: EDGE_DETECT_MULTI_FILTER_EN.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Widest channel count the helper below can address.
  localparam int MAX_CHANNELS = 32;
  localparam int MODE_BUS_W   = 2 * MAX_CHANNELS;

  // Channel idx occupies bits [2*idx+1:2*idx]. Callers zero-extend their
  // mode bus to MODE_BUS_W so one function serves every WIDTH.
  function automatic edge_mode_e chan_mode(input logic [MODE_BUS_W-1:0] bus,
                                           input int unsigned idx);
    return edge_mode_e'(bus[2*idx +: 2]);
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan
// One edge-detector channel: N-flop synchroniser, optional debounce filter,
// level register, registered pulse/direction outputs and a sticky flag.
// Optional feature: define EDGE_DETECT_MULTI_FILTER_EN to compile in the
// debounce counter (FILT_LEN consecutive cycles of a new level required).
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   data_in    in  : raw asynchronous input
//   mode       in  : 2-bit edge select (edge_mode_e encoding)
//   clr        in  : sticky-flag clear, level-sensitive
//   edge_pulse out : one-cycle pulse per enabled edge
//   edge_dir   out : 1 rising / 0 falling, only while edge_pulse is high
//   event_flag out : sticky record of pulses
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       edge_pulse,
  output logic       edge_dir,
  output logic       event_flag
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    $error("edge_detect_chan: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   dir_q, dir_d;
  logic                   flag_q, flag_d;
  logic                   sync_s;
  logic                   rise_en, fall_en;
  edge_mode_e             mode_e;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
  end

`ifdef EDGE_DETECT_MULTI_FILTER_EN
  localparam int              CNT_W    = $clog2(FILT_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level only moves once the synchronised input has disagreed with it
  // for FILT_LEN consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    level_d = sync_s;
  end
`endif

  // The level register runs regardless of mode, so enabling a direction
  // later only reacts to edges that happen after that point.
  always_comb begin
    mode_e  = edge_mode_e'(mode);
    rise_en = (mode_e == EDGE_RISE) || (mode_e == EDGE_BOTH);
    fall_en = (mode_e == EDGE_FALL) || (mode_e == EDGE_BOTH);
    pulse_d = (level_d != level_q) && (level_d ? rise_en : fall_en);
    dir_d   = pulse_d & level_d;
    // Set has priority over clear so a pulse coinciding with clr is kept.
    flag_d  = pulse_q | (flag_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      level_q <= INIT_LEVEL;
      pulse_q <= 1'b0;
      dir_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
      flag_q  <= flag_d;
    end
  end

  assign edge_pulse = pulse_q;
  assign edge_dir   = dir_q;
  assign event_flag = flag_q;

endmodule

// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// WIDTH independent edge-detector channels with per-channel run-time edge
// selection and sticky event flags, plus an OR of all flags.
// Optional feature: define EDGE_DETECT_MULTI_FILTER_EN to add a FILT_LEN-cycle
// debounce in every channel; without it FILT_LEN is ignored.
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   data_in    in  [WIDTH]   : raw asynchronous inputs
//   mode       in  [2*WIDTH] : edge select, channel i at [2i+1:2i]
//   clr        in  [WIDTH]   : per-channel sticky-flag clear
//   edge_pulse out [WIDTH]   : one-cycle edge pulses
//   edge_dir   out [WIDTH]   : direction of the current pulse (1 = rising)
//   event_flag out [WIDTH]   : sticky flags
//   any_event  out           : OR of event_flag
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int   WIDTH       = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     edge_pulse,
  output logic [WIDTH-1:0]     edge_dir,
  output logic [WIDTH-1:0]     event_flag,
  output logic                 any_event
);

  if (WIDTH < 1 || WIDTH > MAX_CHANNELS) begin : g_bad_width
    $error("edge_detect_multi: WIDTH out of range");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [1:0] chan_mode_sel;

    assign chan_mode_sel = chan_mode(MODE_BUS_W'(mode), gi);

    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in[gi]),
      .mode       (chan_mode_sel),
      .clr        (clr[gi]),
      .edge_pulse (edge_pulse[gi]),
      .edge_dir   (edge_dir[gi]),
      .event_flag (event_flag[gi])
    );
  end

  assign any_event = |event_flag;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi
// Directed stimulus for edge_detect_multi. A history-based reference model
// (input samples indexed by cycle, level changes decided from a window of
// past synchronised values) is compared against the DUT every cycle, and
// hand-computed literal expectations pin key points of the scenario.
// Build with EDGE_DETECT_MULTI_FILTER_EN to exercise the debounce filter.
module tb_edge_detect_multi;

  localparam int   WIDTH    = 4;
  localparam int   N        = 2;
  localparam int   FILT_LEN = 4;
  localparam logic INIT     = 1'b0;
`ifdef EDGE_DETECT_MULTI_FILTER_EN
  localparam int   FILT     = FILT_LEN;
`else
  localparam int   FILT     = 1;
`endif
  // Negedges from an input change until the pulse is visible.
  localparam int   LAT      = N + FILT;
  localparam int   HIST     = 4096;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   data_in = '0;
  logic [2*WIDTH-1:0] mode    = '1;
  logic [WIDTH-1:0]   clr     = '0;
  logic [WIDTH-1:0]   edge_pulse, edge_dir, event_flag;
  logic               any_event;

  edge_detect_multi #(
    .WIDTH(WIDTH), .SYNC_STAGES(N), .FILT_LEN(FILT_LEN), .INIT_LEVEL(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .clr(clr),
    .edge_pulse(edge_pulse), .edge_dir(edge_dir), .event_flag(event_flag),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] raw [0:HIST-1];
  int               cyc  = 0;
  int               base = 0;
  logic [WIDTH-1:0] m_lvl = {WIDTH{INIT}};
  logic [WIDTH-1:0] m_pulse = '0, m_dir = '0, m_flag = '0;

  // Value of the synchronised input after sampling edge j.
  function automatic logic s_after(input int ch, input int j);
    int idx;
    idx = j - (N - 1);
    if (idx < base) return INIT;
    return raw[idx][ch];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    = cyc;
      m_lvl   = {WIDTH{INIT}};
      m_pulse = '0;
      m_dir   = '0;
      m_flag  = '0;
    end else begin
      raw[cyc] = data_in;
      for (int ch = 0; ch < WIDTH; ch++) begin
        logic moved, new_lvl;
        m_flag[ch] = m_pulse[ch] | (m_flag[ch] & ~clr[ch]);
        moved = 1'b1;
        for (int w = 1; w <= FILT; w++)
          if (s_after(ch, cyc - w) == m_lvl[ch]) moved = 1'b0;
        new_lvl     = moved ? ~m_lvl[ch] : m_lvl[ch];
        m_pulse[ch] = moved && (new_lvl ? mode[2*ch] : mode[2*ch+1]);
        m_dir[ch]   = m_pulse[ch] & new_lvl;
        m_lvl[ch]   = new_lvl;
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_pulse", edge_pulse, m_pulse);
    check("model_dir",   edge_dir,   m_dir);
    check("model_flag",  event_flag, m_flag);
    check("model_any",   any_event,  |m_flag);
  end

  // Pulse counters per channel, sampled at negedge.
  int pcnt [WIDTH];
  initial for (int i = 0; i < WIDTH; i++) pcnt[i] = 0;
  always @(negedge clk)
    for (int i = 0; i < WIDTH; i++)
      if (edge_pulse[i]) pcnt[i]++;

  function automatic int psum();
    int s = 0;
    for (int i = 0; i < WIDTH; i++) s += pcnt[i];
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c;

    // Reset held, inputs toggling: outputs stay quiet.
    tick(1); data_in = 4'b1010;
    tick(1); data_in = 4'b0101;
    tick(1);
    check("rst_pulse", edge_pulse, 4'b0000);
    check("rst_flag",  event_flag, 4'b0000);
    check("rst_any",   any_event,  1'b0);
    $display("reset hold: pulse=%b flag=%b any=%b", edge_pulse, event_flag, any_event);

    // Input differs from INIT at release: genuine rise on ch0.
    data_in = 4'b0001;
    tick(1); rst_n = 1'b1;
    tick(LAT);
    check("release_pulse", edge_pulse, 4'b0001);
    check("release_dir",   edge_dir,   4'b0001);
    $display("release edge: pulse=%b dir=%b", edge_pulse, edge_dir);
    tick(1);
    check("release_flag", event_flag, 4'b0001);
    check("release_any",  any_event,  1'b1);
    clr = '1; tick(1); clr = '0;
    check("clear_all", event_flag, 4'b0000);

    // ch1 fall-only: 0->1->0 gives a single falling pulse.
    mode = 8'b11_11_10_11;
    c = pcnt[1];
    data_in[1] = 1'b1; tick(10);
    data_in[1] = 1'b0; tick(LAT);
    check("fall_pulse", edge_pulse[1], 1'b1);
    check("fall_dir",   edge_dir[1],   1'b0);
    tick(5);
    check("fall_count", pcnt[1] - c, 1);
    $display("ch1 fall-only: pulses=%0d", pcnt[1] - c);

    // ch1 mode none: level still tracked, enabling rise later is quiet.
    mode = 8'b11_11_00_11;
    c = pcnt[1];
    data_in[1] = 1'b1; tick(10);
    data_in[1] = 1'b0; tick(10);
    data_in[1] = 1'b1; tick(10);
    check("none_count", pcnt[1] - c, 0);
    mode = 8'b11_11_01_11;
    tick(5);
    check("enable_no_spurious", pcnt[1] - c, 0);
    data_in[1] = 1'b0; tick(LAT + 2);
    data_in[1] = 1'b1; tick(LAT);
    check("rise_pulse", edge_pulse[1], 1'b1);
    check("rise_dir",   edge_dir[1],   1'b1);
    $display("ch1 none then rise: pulses=%0d", pcnt[1] - c);
    tick(2); clr = '1; tick(1); clr = '0;

    // Sticky flag on ch2: clear coinciding with a pulse loses to the set.
    data_in[2] = 1'b1; tick(LAT);
    check("sticky_pulse1", edge_pulse[2], 1'b1);
    tick(1);
    check("sticky_flag1", event_flag[2], 1'b1);
    data_in[2] = 1'b0; tick(LAT);
    check("sticky_pulse2", edge_pulse[2], 1'b1);
    clr = 4'b0100; tick(1); clr = '0;
    check("set_wins", event_flag[2], 1'b1);
    $display("ch2 set vs clear: flag=%b", event_flag[2]);
    tick(1);
    clr = '1; tick(1); clr = '0;
    check("clear_flag2", event_flag[2], 1'b0);
    check("clear_any",   any_event,     1'b0);
    $display("ch2 clear: flag=%b any=%b", event_flag[2], any_event);

`ifdef EDGE_DETECT_MULTI_FILTER_EN
    // 3-cycle glitch is absorbed; 4-cycle change pulses after edge N-1+4.
    c = pcnt[3];
    data_in[3] = 1'b1; tick(FILT_LEN - 1);
    data_in[3] = 1'b0; tick(10);
    check("glitch_count", pcnt[3] - c, 0);
    check("glitch_flag",  event_flag[3], 1'b0);
    data_in[3] = 1'b1; tick(LAT - 1);
    check("filt_early", edge_pulse[3], 1'b0);
    tick(1);
    check("filt_pulse", edge_pulse[3], 1'b1);
    $display("ch3 filter: glitch pulses=%0d, stable pulse=%b", 0, edge_pulse[3]);
    data_in[3] = 1'b0; tick(LAT + 2);
`else
    // Toggle every cycle: one pulse per change, direction alternating.
    c = pcnt[3];
    for (int i = 0; i < 8; i++) begin
      data_in[3] = ~data_in[3];
      tick(1);
    end
    tick(LAT + 2);
    check("toggle_count", pcnt[3] - c, 8);
    $display("ch3 toggle: pulses=%0d", pcnt[3] - c);
`endif
    clr = '1; tick(1); clr = '0;

    // All channels rise together.
    data_in = '0; tick(LAT + 3);
    clr = '1; tick(1); clr = '0;
    mode = '1;
    data_in = 4'b1111; tick(LAT);
    check("multi_pulse", edge_pulse, 4'b1111);
    check("multi_dir",   edge_dir,   4'b1111);
    $display("multi rise: pulse=%b dir=%b", edge_pulse, edge_dir);
    tick(3);

    // Reset one cycle after an input change aborts the pending edge.
    data_in = 4'b0000; tick(1);
    rst_n = 1'b0; tick(1);
    check("abort_pulse", edge_pulse, 4'b0000);
    check("abort_flag",  event_flag, 4'b0000);
    tick(1); rst_n = 1'b1;
    c = psum();
    tick(10);
    check("abort_no_pulse", psum() - c, 0);
    check("abort_any",      any_event,  1'b0);
    $display("reset mid-edge: pulses=%0d flag=%b", psum() - c, event_flag);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector; generalises the single-channel falling-edge detector. Each channel synchronises an asynchronous input, optionally debounces it, and raises a one-cycle pulse on rising, falling or both edges as selected per channel at run time. Pulses are latched into sticky flags with per-channel clear. The block sits between SPI/EEPROM-side pins (CS, WP, HOLD, status lines) and the controller logic that consumes edge events.

## Interface
- `WIDTH`, 4: number of independent channels, at least 1.
- `SYNC_STAGES`, 2: synchroniser depth N, at least 2.
- `FILT_LEN`, 4: debounce length in cycles, at least 1. Used only with the filter compiled in.
- `INIT_LEVEL`, 1'b0: reset value of every synchroniser flop and level register.

- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `data_in`, in, WIDTH: raw asynchronous inputs.
- `mode`, in, 2*WIDTH: per-channel edge select, bits [2i+1:2i]. Values: 00 none, 01 rise, 10 fall, 11 both.
- `clr`, in, WIDTH: per-channel sticky-flag clear, level-sensitive.
- `edge_pulse`, out, WIDTH: registered one-cycle pulse per enabled edge.
- `edge_dir`, out, WIDTH: 1 = rising, 0 = falling. Valid only while `edge_pulse[i]` is high; otherwise 0.
- `event_flag`, out, WIDTH: sticky record of pulses.
- `any_event`, out, 1: OR of `event_flag`.

## Operation
Per-channel datapath:
- N-flop synchroniser on `data_in[i]`; `s` = last stage.
- Level register `L`, which tracks the filtered level. Next value `Ln` is `s`, or the debounced value when the filter is enabled.
- `L` always updates, whatever the `mode` value. Because the level keeps being tracked, enabling a mode never produces a stale or spurious edge.

Edge pulse:
- `edge_pulse` <= (`Ln` != `L`) AND the mode bit for that direction is set. A rise needs mode bit 0; a fall needs mode bit 1.
- `edge_dir` <= `Ln`, gated by the pulse.
- A mode change takes effect on the next comparison. It never cancels a pulse already registered.

Sticky flag:
- `event_flag[i]` is set by `edge_pulse[i]` and cleared by `clr[i]`.
- If set and clear occur in the same cycle, set wins, so no event is lost.
- `any_event` is combinational OR of the flags.

Reset (asynchronous, `rst_n` low):
- Synchroniser flops and `L` go to `INIT_LEVEL`.
- `edge_pulse`, `edge_dir`, `event_flag` and `any_event` go to 0.
- Filter counters go to 0.
- Reset asserted mid-filter or mid-pulse aborts immediately; no pulse is emitted for the aborted edge.
- If an input differs from `INIT_LEVEL` at reset release, that is a genuine edge and pulses N edges later, if enabled.

Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.

## Timing
Latency is counted from the `clk` edge that first samples the new input level:
- Filter off: `edge_pulse` goes high after edge N and lasts exactly 1 cycle.
- Filter on: pulse goes high after edge N-1+FILT_LEN.
- With FILT_LEN=1 the filtered timing equals the unfiltered timing.

Back-to-back edges:
- Filter off: an input toggling every cycle (after synchronisation) gives a pulse every cycle, with `edge_dir` alternating.
- Input stable for less than one cycle may be missed; this is inherent to synchronisation.

The sticky flag is visible 1 cycle after the pulse. `clr` takes effect at the next edge.

## Configuration
Macro `EDGE_DETECT_MULTI_FILTER_EN`.

Defined:
- Per-channel counter, clog2(FILT_LEN)+1 bits.
- While `s` != `L`, the counter increments. When it reaches FILT_LEN-1 with `s` still different, `Ln` = `s` and the counter clears.
- When `s` == `L`, the counter clears. A glitch shorter than FILT_LEN cycles produces no pulse and leaves `L` unchanged.

Undefined:
- No counter; `Ln` = `s`; `FILT_LEN` is ignored.

## Structure
- Package `edge_detect_pkg` holds:
  - the 2-bit mode type with constants EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - a helper that extracts channel i's mode from the `mode` bus.
- Sub-module `edge_detect_chan` contains one channel: synchroniser, optional filter, level register, pulse/dir registers and sticky flag.
- The top level instantiates `edge_detect_chan` WIDTH times with a generate loop and ORs the flags into `any_event`.

## Test plan
- Reset: `rst_n` low, toggle `data_in` -> all outputs stay 0. Release with INIT_LEVEL=0 and data_in[0]=1, mode=11 -> rise pulse after edge 2 (N=2), `edge_dir[0]`=1.
- Mode select: ch1 mode=10, drive 0->1->0 with a 10-cycle gap -> a single pulse on the fall, `edge_dir`=0. Repeat with mode=00 -> no pulse, but `L` still tracks, so enabling mode=01 later gives no spurious pulse.
- Sticky/clear: pulse on ch2, then hold `clr[2]` high in the same cycle as a new pulse -> `event_flag[2]` stays 1. Clear alone -> 0, and `any_event` = 0.
- Filter on, FILT_LEN=4: a 3-cycle glitch -> no pulse. A 4-cycle stable change -> pulse after edge N-1+4 = 5.
- Multi-channel and reset mid-operation: simultaneous rises on all 4 channels -> four pulses in the same cycle. Assert `rst_n` low 1 cycle after the input change -> no pulse, all flags 0.
